// File: rtl/instruction_sequencer.sv
// instruction_sequencer: multi-cycle RV32I control FSM.
// Sequences FETCH -> DECODE -> EXECUTE -> (MEMORY) -> WRITEBACK around an
// external field decoder and ALU, owns the PC and the instruction register,
// and halts in TRAP on illegal opcodes or misaligned redirect targets.
// Optional feature: define INSTRET_COUNTER_EN to add the instret counter.
//
// Handshakes: a request (imem_req / dmem_req) is a registered level that
// stays high until the matching ready is sampled high on a rising edge
// while the request is high; that edge completes the transfer and the
// request drops on the same edge. A ready seen with no request is ignored.
module instruction_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          INSTRET_WIDTH = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] target_pc,
  output logic        exec_en,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        reg_write_en,
  output logic        retire,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state
`ifdef INSTRET_COUNTER_EN
  ,
  output logic [INSTRET_WIDTH-1:0] instret
`endif
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] next_pc_q;

  logic is_legal;
  logic is_jump;
  logic is_branch;
  logic is_load;
  logic is_store;
  logic has_rd;
  logic writes_rd;
  logic redirect;

  assign state       = state_q;
  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign instruction = ir_q;

  // Opcode classification of the instruction register.
  always_comb begin
    is_legal  = 1'b0;
    is_jump   = 1'b0;
    is_branch = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    has_rd    = 1'b0;
    case (ir_q[6:0])
      OP_LUI, OP_AUIPC, OP_IMM, OP_OP: begin
        is_legal = 1'b1;
        has_rd   = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        is_legal = 1'b1;
        is_jump  = 1'b1;
        has_rd   = 1'b1;
      end
      OP_BRANCH: begin
        is_legal  = 1'b1;
        is_branch = 1'b1;
      end
      OP_LOAD: begin
        is_legal = 1'b1;
        is_load  = 1'b1;
        has_rd   = 1'b1;
      end
      OP_STORE: begin
        is_legal = 1'b1;
        is_store = 1'b1;
      end
      OP_FENCE, OP_SYSTEM: begin
        is_legal = 1'b1;
      end
      default: begin
        is_legal = 1'b0;
      end
    endcase
  end

  // x0 is hardwired, so a zero rd never produces a write strobe.
  assign writes_rd = has_rd && (ir_q[11:7] != 5'd0);
  assign redirect  = is_jump || (is_branch && branch_taken);

  // Control FSM; every strobe and request is registered alongside the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= NOP_WORD;
      next_pc_q    <= RESET_PC;
      imem_req     <= 1'b0;
      exec_en      <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      reg_write_en <= 1'b0;
      retire       <= 1'b0;
      trap         <= 1'b0;
      trap_cause   <= 2'b00;
    end else begin
      exec_en      <= 1'b0;
      reg_write_en <= 1'b0;
      retire       <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (imem_req && imem_ready) begin
            ir_q     <= imem_rdata;
            imem_req <= 1'b0;
            state_q  <= S_DECODE;
          end else begin
            // First cycle after reset raises the request here.
            imem_req <= 1'b1;
          end
        end
        S_DECODE: begin
          if (is_legal) begin
            exec_en <= 1'b1;
            state_q <= S_EXECUTE;
          end else begin
            trap       <= 1'b1;
            trap_cause <= 2'b01;
            state_q    <= S_TRAP;
          end
        end
        S_EXECUTE: begin
          if (redirect && (target_pc[1:0] != 2'b00)) begin
            trap       <= 1'b1;
            trap_cause <= 2'b10;
            state_q    <= S_TRAP;
          end else begin
            next_pc_q <= redirect ? target_pc : (pc_q + 32'd4);
            if (is_load || is_store) begin
              dmem_req <= 1'b1;
              dmem_we  <= is_store;
              state_q  <= S_MEMORY;
            end else begin
              reg_write_en <= writes_rd;
              retire       <= 1'b1;
              state_q      <= S_WRITEBACK;
            end
          end
        end
        S_MEMORY: begin
          if (dmem_ready) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            reg_write_en <= writes_rd;
            retire       <= 1'b1;
            state_q      <= S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          pc_q     <= next_pc_q;
          imem_req <= 1'b1;
          state_q  <= S_FETCH;
        end
        S_TRAP: begin
          // Halted: everything holds until reset.
        end
        default: begin
          imem_req <= 1'b0;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
          state_q  <= S_FETCH;
        end
      endcase
    end
  end

`ifdef INSTRET_COUNTER_EN
  // Retired-instruction counter; wraps naturally, never counts in TRAP.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + 1'b1;
    end
  end
`endif

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Multi-cycle RV32I control FSM that sequences fetch, decode, execute, memory and writeback around the field decoder and ALU.
- Owns the PC and the instruction register feeding the decoder.
- Drives the instruction/data memory handshakes and the register-file write enable.
- Traps and halts on illegal opcodes or misaligned control-flow targets.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
INSTRET_WIDTH, 32, width of optional retire counter

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
imem_req  output  1  instruction fetch request
imem_addr  output  32  fetch address (equals pc)
imem_ready  input  1  fetch data valid this cycle
imem_rdata  input  32  fetched instruction word
instruction  output  32  instruction register, to decoder
pc  output  32  current PC
branch_taken  input  1  branch compare result, valid in EXECUTE
target_pc  input  32  jump/branch target, valid in EXECUTE
exec_en  output  1  ALU/decode result strobe (EXECUTE)
dmem_req  output  1  data memory request
dmem_we  output  1  data write (store)
dmem_ready  input  1  data access complete
reg_write_en  output  1  register-file write strobe
retire  output  1  one-cycle pulse per completed instruction
trap  output  1  halted in TRAP
trap_cause  output  2  01 illegal instruction, 10 misaligned target
state  output  3  FSM state: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5

Behaviour:
- Reset values (asynchronous, immediate, including mid-operation):
  - pc=RESET_PC; instruction=32'h0000_0013 (NOP).
  - All strobes/requests 0; trap=0; trap_cause=0; state=FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc, held until imem_ready=1.
  - On that edge: instruction<=imem_rdata, go to DECODE.
  - imem_ready is ignored in every other state.
- DECODE (exactly 1 cycle, lets decoder immediates register):
  - Classify instruction[6:0].
  - Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011.
  - Any other opcode → TRAP with cause 01. instruction[1:0]!=2'b11 is covered by this rule.
- EXECUTE (1 cycle): exec_en=1.
  - Compute next_pc: target_pc for JAL/JALR, or for BRANCH with branch_taken=1; else pc+4 (modulo 2^32, wraps).
  - Redirect with target_pc[1:0]!=0 → TRAP with cause 10; pc unchanged.
  - LOAD/STORE → MEMORY; all others → WRITEBACK.
- MEMORY:
  - dmem_req=1; dmem_we=1 for STORE only; held until dmem_ready=1.
  - Then → WRITEBACK. dmem_ready outside MEMORY is ignored.
- WRITEBACK (1 cycle):
  - reg_write_en=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and only when rd (instruction[11:7]) != 0.
  - pc<=next_pc; retire=1; → FETCH.
  - FENCE and SYSTEM (incl. ECALL/EBREAK) retire as NOPs with no register write.
- TRAP:
  - trap=1; trap_cause held.
  - No requests, pc and instruction frozen, no retire.
  - Exit only via reset.
- Latency with zero-wait memories:
  - ALU/jump/branch: 4 cycles per instruction.
  - Load/store: 5 cycles.
  - Each extra wait cycle adds 1.
- Outputs are registered or decoded from registered state only; no combinational path from imem_ready/dmem_ready to any output.

Optional Feature:
INSTRET_COUNTER_EN
- Defined:
  - Adds output instret[INSTRET_WIDTH-1:0], reset to 0.
  - Increments on every retire pulse, wraps to 0 at all-ones.
  - Frozen in TRAP.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, imem_ready tied 1, imem_rdata=32'h00500093 (addi x1,x0,5) → imem_addr=0 at cycle 1; reg_write_en and retire at cycle 4; pc=4 at cycle 5.
- imem_rdata=32'h0000A103 (lw x2,0(x1)), dmem_ready delayed 3 cycles → dmem_req high 4 cycles with dmem_we=0; retire on cycle 8 after fetch start.
- BRANCH 32'h00000463, branch_taken=1, target_pc=32'h100 → no reg_write_en; next fetch imem_addr=32'h100. With branch_taken=0 → imem_addr=pc+4.
- JAL with target_pc=32'h102 → trap=1, trap_cause=10, pc unchanged, imem_req stays 0 for 20 cycles.
- imem_rdata=32'hFFFFFFFF → trap_cause=01 after DECODE. Asserting reset_n=0 during FETCH wait clears imem_req the same cycle; pc=RESET_PC.
- With INSTRET_COUNTER_EN and INSTRET_WIDTH=4: 17 NOPs retired → instret=1 (wrapped).
